// File: rtl/fetch_unit_param_if.sv
// Purpose: bundles the fetch-stage control, program-load and decode-side signals.
// Latency: none, wiring only.
// Backpressure: carries the out_valid/out_ready pair between fetch and decode.
interface fetch_unit_param_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int IDX_W  = 5
);
  // Control-unit redirect request
  logic [1:0]        pc_src;
  logic [PC_W-1:0]   redirect_base;
  logic [PC_W-1:0]   redirect_offset;

  // Program-load write port
  logic              prog_we;
  logic [IDX_W-1:0]  prog_addr;
  logic [DATA_W-1:0] prog_data;

  // Decode-side handshake and payload
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] instr;
  logic [PC_W-1:0]   instr_pc;

  // Status
  logic [PC_W-1:0]   pc;
  logic              fault;

  // Fetch unit side
  modport master (
    input  pc_src, redirect_base, redirect_offset,
    input  prog_we, prog_addr, prog_data,
    input  out_ready,
    output out_valid, instr, instr_pc, pc, fault
  );

  // Control unit / decode / loader side
  modport slave (
    output pc_src, redirect_base, redirect_offset,
    output prog_we, prog_addr, prog_data,
    output out_ready,
    input  out_valid, instr, instr_pc, pc, fault
  );
endinterface

// File: rtl/fetch_unit_param.sv
// Purpose: program counter plus word-addressed instruction store with registered fetch, redirect and sticky range fault.
// Latency: instruction valid 1 cycle after its PC is presented; redirect target valid 2 cycles after the redirect edge.
// Backpressure: holds instr/instr_pc/pc while out_valid && !out_ready; a redirect flushes the held word regardless.
module fetch_unit_param #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int DEPTH    = 32,
  parameter int IDX_W    = 5,
  parameter int RESET_PC = 0
) (
  input  logic             clk,
  input  logic             reset,
  fetch_unit_param_if.master bus
);

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
  // Depth widened by one bit so DEPTH == 2^PC_W (or 2^IDX_W) is representable.
  localparam logic [PC_W:0]   DEPTH_PC   = (PC_W+1)'(DEPTH);
  localparam logic [IDX_W:0]  DEPTH_IDX  = (IDX_W+1)'(DEPTH);
  localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

  localparam logic [1:0] SRC_REL = 2'b01;
  localparam logic [1:0] SRC_ABS = 2'b10;

  // Architectural state
  logic [PC_W-1:0]   pc_q,       pc_d;
  logic              vld_q,      vld_d;
  logic [DATA_W-1:0] instr_q,    instr_d;
  logic [PC_W-1:0]   instr_pc_q, instr_pc_d;
  logic              fault_q,    fault_d;

  // Instruction store; deliberately not reset so a loaded program survives reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Decoded per-cycle conditions
  logic              redirect;
  logic [PC_W-1:0]   target;
  logic              advance;
  logic              pc_in_range;
  logic              wr_in_range;
  logic [DATA_W-1:0] rd_dat;

  // Decode redirect mode and target; mode 11 falls through as "no redirect".
  always_comb begin
    redirect = (bus.pc_src == SRC_REL) || (bus.pc_src == SRC_ABS);
    target   = bus.redirect_offset;
    if (bus.pc_src == SRC_REL) begin
      // Two's-complement add, silently truncated to PC_W.
      target = bus.redirect_base + bus.redirect_offset;
    end
  end

  // Handshake and range qualifiers for this cycle.
  always_comb begin
    advance     = !vld_q || bus.out_ready;
    pc_in_range = {1'b0, pc_q} < DEPTH_PC;
    wr_in_range = {1'b0, bus.prog_addr} < DEPTH_IDX;
    // Reads the pre-edge array contents, which gives read-before-write on a same-index collision.
    rd_dat      = mem_q[pc_q[IDX_W-1:0]];
  end

  // Next-state selection in priority order: redirect, fault, fetch, hold.
  always_comb begin
    pc_d       = pc_q;
    vld_d      = vld_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_d    = fault_q;

    if (redirect) begin
      // Flush even if decode accepts this cycle: upstream discards that transfer.
      pc_d  = target;
      vld_d = 1'b0;
    end else if (advance && !pc_in_range) begin
      // PC stalls out of range until a redirect brings it back.
      fault_d = 1'b1;
      vld_d   = 1'b0;
    end else if (advance) begin
      instr_d    = rd_dat;
      instr_pc_d = pc_q;
      vld_d      = 1'b1;
      pc_d       = pc_q + PC_ONE;
    end
  end

  // Pipeline and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC_V;
      vld_q      <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      vld_q      <= vld_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      fault_q    <= fault_d;
    end
  end

  // Program-load writes, independent of reset and the fetch handshake.
  always_ff @(posedge clk) begin
    if (bus.prog_we && wr_in_range) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.instr     = instr_q;
  assign bus.instr_pc  = instr_pc_q;
  assign bus.pc        = pc_q;
  assign bus.fault     = fault_q;

endmodule

// File: doc/fetch_unit_param.md
Name: fetch_unit_param

Overview:
- Parametrised instruction fetch stage: program counter, word-addressed instruction store, 1-cycle registered fetch.
- Adds an output valid/ready handshake with back-pressure, flush on redirect, relative and absolute redirect modes, a program-load write port and a sticky out-of-range fault.
- Sits between the control unit, which supplies pc_src and redirect info, and the decode stage, which consumes instr/instr_pc.

Parameters:
- DATA_W, 32: instruction width in bits.
- PC_W, 32: program counter width. The PC counts words, not bytes.
- DEPTH, 32: number of instruction words. Must be at most 2^PC_W.
- IDX_W, 5: memory index width. Must satisfy 2^IDX_W >= DEPTH.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_src  in  2  redirect select: 00 = none, 01 = relative (redirect_base + redirect_offset), 10 = absolute (redirect_offset), 11 = reserved, ignored.
- redirect_base  in  PC_W  PC of the redirecting instruction.
- redirect_offset  in  PC_W  two's-complement offset for mode 01; absolute target for mode 10.
- prog_we  in  1  program-load write enable.
- prog_addr  in  IDX_W  program-load word index.
- prog_data  in  DATA_W  program-load data.
- out_ready  in  1  decode stage can accept this cycle.
- out_valid  out  1  instr and instr_pc are valid.
- instr  out  DATA_W  fetched instruction.
- instr_pc  out  PC_W  PC the instruction was fetched from.
- pc  out  PC_W  current fetch PC.
- fault  out  1  sticky: a fetch was attempted with pc >= DEPTH.

Behaviour:
- Reset (synchronous, active-high), applied on any cycle including mid-stall or mid-redirect:
  - pc = RESET_PC; out_valid = 0; instr = 0; instr_pc = 0; fault = 0.
  - Memory contents are not cleared.
- Definitions:
  - redirect = pc_src is 01 or 10.
  - advance = !out_valid || out_ready.
- Priority per cycle, highest first:
  1. reset.
  2. redirect: pc <= target; out_valid <= 0. Any held instruction is flushed, even if out_ready = 1 that cycle, since the consumer's transfer is discarded upstream. instr and instr_pc hold their values.
  3. fault condition (advance and pc >= DEPTH): fault <= 1; out_valid <= 0; pc holds.
  4. advance and pc < DEPTH: instr <= mem[pc[IDX_W-1:0]]; instr_pc <= pc; out_valid <= 1; pc <= pc + 1, wrapping modulo 2^PC_W.
  5. Otherwise (out_valid = 1 and out_ready = 0): everything holds.
- Latency:
  - An instruction appears 1 cycle after its PC is presented.
  - The first valid instruction appears 1 cycle after reset deasserts.
  - After a redirect, the first valid instruction is the target word, 2 cycles after the redirect edge.
- Throughput: 1 instruction per cycle while out_ready is held high.
- Relative target arithmetic: redirect_base + redirect_offset, truncated to PC_W. No overflow flag.
- pc_src = 11 behaves exactly as 00.
- Fault:
  - Stays set until reset.
  - The fetch PC stalls while pc >= DEPTH. A subsequent redirect to a legal PC resumes fetching, but fault remains set.
- Program write port:
  - mem[prog_addr] <= prog_data on the rising edge when prog_we = 1. Writes are independent of the handshake.
  - prog_addr >= DEPTH: the write is ignored.
  - Same-cycle write and fetch to the same index: the fetch returns the old data (read-before-write).
- Stable-output rule: while out_valid = 1 and out_ready = 0 with no redirect, instr and instr_pc must not change.

Test Plan:
- Load mem[0..3] = 0x11, 0x22, 0x33, 0x44. Release reset with out_ready = 1. Required: out_valid rises 1 cycle later; instr/instr_pc sequence is (0x11,0), (0x22,1), (0x33,2), (0x44,3) on consecutive cycles.
- Back-pressure: at instr_pc = 1, hold out_ready = 0 for 3 cycles. Required: instr = 0x22 and pc = 2 hold; 0x33 follows the cycle after out_ready returns to 1.
- Relative redirect: while instr_pc = 2 is valid, drive pc_src = 01, base = 2, offset = -2 (all ones). Required: out_valid = 0 on the next cycle, then (0x11,0). pc_src = 11 in the same setup produces no change to the sequence.
- Absolute redirect during a stall: out_ready = 0, pc_src = 10, offset = 3. Required: the held instruction is flushed, and the next valid output is (0x44,3).
- Fault: DEPTH = 32; redirect absolute to 31 with out_ready = 1. Required: the word at 31 is delivered, then fault = 1, out_valid = 0 and pc holds at 32. A redirect to 0 resumes fetching with fault still 1; reset clears fault.
- Write/fetch collision: with pc = 5 and mem[5] = 0xAA, write mem[5] = 0xBB in the same cycle. Required: instr = 0xAA. A redirect back to 5 then yields 0xBB.
